// File: rtl/seq_step_controller.sv
// seq_step_controller
//
// Purpose:
//   A 16-step (by default) sequence controller. A start strobe in IDLE
//   begins a pass at step 0. Each advance strobe in RUN moves one step on.
//   An advance on the final step ends the pass, pulses done for one cycle
//   and bumps the 8-bit pass counter. Abort cancels a pass with no done
//   pulse and wins over start and advance. Every output comes straight
//   from a flop, so no input reaches an output combinationally.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active low
//   start        in   1      begin a pass (IDLE only)
//   advance      in   1      step strobe (RUN only)
//   abort        in   1      cancel the pass (highest priority)
//   cur_state    out  SW     current step index
//   step_onehot  out  STEPS  one-hot copy of cur_state while busy, else 0
//   busy         out  1      high while in RUN
//   done         out  1      one-cycle pulse at the end of a pass
//   pass_count   out  8      completed passes, modulo 256

module seq_step_controller #(
  parameter int STEPS = 16,
  parameter int SW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             advance,
  input  logic             abort,
  output logic [SW-1:0]    cur_state,
  output logic [STEPS-1:0] step_onehot,
  output logic             busy,
  output logic             done,
  output logic [7:0]       pass_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  localparam logic [SW-1:0]    LAST_STEP = SW'(STEPS - 1);
  localparam logic [STEPS-1:0] FIRST_HOT = STEPS'(1);

  stateT            state, stateNext;
  logic [SW-1:0]    curState, curNext;
  logic [STEPS-1:0] stepOnehot, onehotNext;
  logic             busyQ, busyNext;
  logic             doneQ, doneNext;
  logic [7:0]       passCount, passNext;

  // Next-state and next-output decode. Every register holds by default,
  // except done, which is a pulse and so clears unless this cycle ends a
  // pass. Leaving RUN (by abort or by finishing) always returns the step
  // index and one-hot select to zero, so IDLE always sits at step 0.
  always_comb begin
    stateNext  = state;
    curNext    = curState;
    onehotNext = stepOnehot;
    busyNext   = busyQ;
    doneNext   = 1'b0;
    passNext   = passCount;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          stateNext  = RUN;
          curNext    = '0;
          onehotNext = FIRST_HOT;
          busyNext   = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          stateNext  = IDLE;
          curNext    = '0;
          onehotNext = '0;
          busyNext   = 1'b0;
        end else if (advance) begin
          if (curState == LAST_STEP) begin
            stateNext  = IDLE;
            curNext    = '0;
            onehotNext = '0;
            busyNext   = 1'b0;
            doneNext   = 1'b1;
            passNext   = passCount + 8'd1;
          end else begin
            curNext    = curState + SW'(1);
            onehotNext = stepOnehot << 1;
          end
        end
      end

      default: begin
        stateNext  = IDLE;
        curNext    = '0;
        onehotNext = '0;
        busyNext   = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and simply drops
  // everything to zero, including mid-pass, so it never produces a done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      curState   <= '0;
      stepOnehot <= '0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
      passCount  <= 8'd0;
    end else begin
      state      <= stateNext;
      curState   <= curNext;
      stepOnehot <= onehotNext;
      busyQ      <= busyNext;
      doneQ      <= doneNext;
      passCount  <= passNext;
    end
  end

  assign cur_state   = curState;
  assign step_onehot = stepOnehot;
  assign busy        = busyQ;
  assign done        = doneQ;
  assign pass_count  = passCount;

endmodule

// File: tb/tb_seq_step_controller.sv
// tb_seq_step_controller
//
// Purpose:
//   Self-checking bench for seq_step_controller with the default
//   STEPS=16, SW=16. A table of single-cycle vectors covers reset,
//   ignored strobes and abort priority. Hand-written sequences then cover
//   the full pass, alternate-cycle advancing, abort mid-pass, 256
//   back-to-back passes with counter wrap, and reset mid-pass.

module tb_seq_step_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        advance;
  logic        abort;
  logic [15:0] cur_state;
  logic [15:0] step_onehot;
  logic        busy;
  logic        done;
  logic [7:0]  pass_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstN;
    logic        start;
    logic        advance;
    logic        abort;
    logic [15:0] expCur;
    logic [15:0] expOnehot;
    logic        expBusy;
    logic        expDone;
    logic [7:0]  expPass;
  } vecT;

  vecT vecs[13];

  seq_step_controller #(.STEPS(16), .SW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .advance     (advance),
    .abort       (abort),
    .cur_state   (cur_state),
    .step_onehot (step_onehot),
    .busy        (busy),
    .done        (done),
    .pass_count  (pass_count)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for one cycle, let the edge happen, then settle 1 unit
  // past it so outputs are sampled well away from the active edge.
  task automatic applyStimulus(input logic r, input logic s,
                               input logic a, input logic ab);
    rst_n   = r;
    start   = s;
    advance = a;
    abort   = ab;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected values.
  task automatic checkOutput(input string name, input logic [15:0] eCur,
                             input logic [15:0] eOh, input logic eBusy,
                             input logic eDone, input logic [7:0] ePass);
    checks++;
    if (cur_state !== eCur) begin
      errors++;
      $display("[TB] FAIL %s cur_state got %0d want %0d", name, cur_state, eCur);
    end
    checks++;
    if (step_onehot !== eOh) begin
      errors++;
      $display("[TB] FAIL %s step_onehot got %h want %h", name, step_onehot, eOh);
    end
    checks++;
    if (busy !== eBusy) begin
      errors++;
      $display("[TB] FAIL %s busy got %b want %b", name, busy, eBusy);
    end
    checks++;
    if (done !== eDone) begin
      errors++;
      $display("[TB] FAIL %s done got %b want %b", name, done, eDone);
    end
    checks++;
    if (pass_count !== ePass) begin
      errors++;
      $display("[TB] FAIL %s pass_count got %0d want %0d", name, pass_count, ePass);
    end
  endtask

  // Main sequence: vector table first, then multi-cycle scenarios.
  initial begin
    logic [7:0]  expPass;
    logic [15:0] hot;

    rst_n = 1'b0; start = 1'b0; advance = 1'b0; abort = 1'b0;

    //               rst start adv abort  cur    onehot   busy done pass
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0001, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'h0002, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'h0002, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'h0002, 1'b1, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 16'h0004, 1'b1, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 16'h0008, 1'b1, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].start, vecs[i].advance, vecs[i].abort);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCur, vecs[i].expOnehot,
                  vecs[i].expBusy, vecs[i].expDone, vecs[i].expPass);
    end

    // Full pass with advance held high.
    expPass = 8'd0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("full_start", 16'd0, 16'h0001, 1'b1, 1'b0, expPass);
    for (int k = 1; k < 16; k++) begin
      hot = 16'h0001 << k;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("full_step%0d", k), 16'(k), hot, 1'b1, 1'b0, expPass);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    expPass = expPass + 8'd1;
    checkOutput("full_done", 16'd0, 16'h0000, 1'b0, 1'b1, expPass);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("full_done_clear", 16'd0, 16'h0000, 1'b0, 1'b0, expPass);

    // Advance only on every other cycle; done lands 32 cycles after start.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("alt_start", 16'd0, 16'h0001, 1'b1, 1'b0, expPass);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 2 == 0), 1'b0);
      if (i < 32) begin
        hot = 16'h0001 << (i / 2);
        checkOutput($sformatf("alt_cyc%0d", i), 16'(i / 2), hot, 1'b1, 1'b0, expPass);
      end else begin
        expPass = expPass + 8'd1;
        checkOutput("alt_done", 16'd0, 16'h0000, 1'b0, 1'b1, expPass);
      end
    end

    // Abort at step 7: no done, counter unchanged.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_at7", 16'd7, 16'h0080, 1'b1, 1'b0, expPass);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("abort_idle", 16'd0, 16'h0000, 1'b0, 1'b0, expPass);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_nodone", 16'd0, 16'h0000, 1'b0, 1'b0, expPass);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("start_abort_idle", 16'd0, 16'h0000, 1'b0, 1'b0, expPass);

    // 256 back-to-back passes from a fresh reset, restarting in each done cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expPass = 8'd0;
    checkOutput("b2b_reset", 16'd0, 16'h0000, 1'b0, 1'b0, expPass);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int p = 1; p <= 256; p++) begin
      for (int k = 1; k < 16; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      if (p == 1 || p == 255 || p == 256)
        checkOutput($sformatf("b2b_last%0d", p), 16'd15, 16'h8000, 1'b1, 1'b0, expPass);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      expPass = expPass + 8'd1;
      checkOutput($sformatf("b2b_done%0d", p), 16'd0, 16'h0000, 1'b0, 1'b1, expPass);
      if (p < 256) begin
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        if (p == 1 || p == 128 || p == 255)
          checkOutput($sformatf("b2b_restart%0d", p), 16'd0, 16'h0001, 1'b1, 1'b0, expPass);
      end
    end
    checks++;
    if (pass_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL b2b_wrap pass_count got %0d want 0", pass_count);
    end

    // Reset at step 12 while advance is high.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_at12", 16'd12, 16'h1000, 1'b1, 1'b0, expPass);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_mid", 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_after", 16'd0, 16'h0000, 1'b0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
